// File: rtl/eth_rgmii_pkg.sv
// eth_rgmii_pkg: shared types and constants for the RGMII receive path
package eth_rgmii_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA, ST_DROP} rx_state_t;
  localparam logic [7:0] ETH_PREAMBLE = 8'h55;
  localparam logic [7:0] ETH_SFD = 8'hD5;
  localparam logic [1:0] SPD_10 = 2'b00;
  localparam logic [1:0] SPD_100 = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;
  localparam int DEF_MAX_FRAME = 1522;
  function automatic logic speed_ok(input logic [1:0] s);
    return s inside {SPD_10, SPD_100, SPD_1000};
  endfunction
endpackage

// File: rtl/rgmii_rx_ddr.sv
// rgmii_rx_ddr: same-edge-pipelined DDR capture plus one register stage to GMII
module rgmii_rx_ddr (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_ctl,
  input  logic [3:0] rxd,
  output logic       rx_dv,
  output logic       rx_er,
  output logic [7:0] rx_data
);
  logic [4:0] r_rise, r_fall, q1, q2;
  always_ff @(posedge clk) r_rise <= {rx_ctl, rxd};
  always_ff @(negedge clk) r_fall <= {rx_ctl, rxd};
  // rising and following falling samples re-aligned onto the same rising edge
  always_ff @(posedge clk) begin
    q1 <= r_rise;
    q2 <= r_fall;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_dv <= 1'b0;
      rx_er <= 1'b0;
      rx_data <= 8'd0;
    end else begin
      rx_dv <= q1[4];
      rx_er <= q1[4] ^ q2[4];
      rx_data <= {q2[3:0], q1[3:0]};
    end
endmodule

// File: rtl/rgmii_rx_frame.sv
// rgmii_rx_frame: RGMII receive front end with preamble strip, framing and in-band status
module rgmii_rx_frame import eth_rgmii_pkg::*; #(
  parameter int MIN_PRE = 1,
  parameter int MAX_PRE = 15,
  parameter int MAX_FRAME = DEF_MAX_FRAME,
  parameter int STATUS_STABLE = 2
) (
  input  logic        rgmii_rxc,
  input  logic        rst,
  input  logic        rgmii_rx_ctl,
  input  logic [3:0]  rgmii_rxd,
  output logic        gmii_rx_clk,
  output logic        gmii_rx_dv,
  output logic        gmii_rx_er,
  output logic [7:0]  gmii_rxd,
  output logic        frm_valid,
  output logic [7:0]  frm_data,
  output logic        frm_sof,
  output logic        frm_eof,
  output logic        frm_err,
  output logic [15:0] frm_len,
  output logic        link_up,
  output logic [1:0]  link_speed,
  output logic        full_duplex
);
  localparam logic [7:0] MIN_PRE_C = 8'(MIN_PRE);
  localparam logic [7:0] MAX_PRE_C = 8'(MAX_PRE);
  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME);
  localparam logic [3:0] STABLE_C = 4'(STATUS_STABLE);
  rx_state_t state;
  logic boot, hold_v, hold_sof, err, qual;
  logic [7:0] hold_d, pre_cnt;
  logic [15:0] len;
  logic [3:0] st_last, st_cnt, st_next;
  assign gmii_rx_clk = rgmii_rxc;
  rgmii_rx_ddr u_ddr (
    .clk(rgmii_rxc),
    .rst(rst),
    .rx_ctl(rgmii_rx_ctl),
    .rxd(rgmii_rxd),
    .rx_dv(gmii_rx_dv),
    .rx_er(gmii_rx_er),
    .rx_data(gmii_rxd)
  );
  // boot holds DROP for the first cycle after reset so a frame already in flight is discarded
  always_ff @(posedge rgmii_rxc or posedge rst)
    if (rst) begin
      state <= ST_DROP;
      boot <= 1'b1;
      pre_cnt <= 8'd0;
      hold_v <= 1'b0;
      hold_sof <= 1'b0;
      hold_d <= 8'd0;
      len <= 16'd0;
      err <= 1'b0;
      frm_valid <= 1'b0;
      frm_data <= 8'd0;
      frm_sof <= 1'b0;
      frm_eof <= 1'b0;
      frm_err <= 1'b0;
      frm_len <= 16'd0;
    end else begin
      boot <= 1'b0;
      frm_valid <= 1'b0;
      frm_sof <= 1'b0;
      frm_eof <= 1'b0;
      frm_err <= 1'b0;
      frm_len <= 16'd0;
      case (state)
        ST_IDLE:
          if (gmii_rx_dv) begin
            state <= (gmii_rxd == ETH_PREAMBLE) ? ST_PRE : ST_DROP;
            pre_cnt <= 8'd1;
          end
        ST_PRE:
          if (!gmii_rx_dv) state <= ST_IDLE;
          else if (gmii_rxd == ETH_PREAMBLE) begin
            if (pre_cnt >= MAX_PRE_C) state <= ST_DROP;
            else pre_cnt <= pre_cnt + 8'd1;
          end else if (gmii_rxd == ETH_SFD && pre_cnt >= MIN_PRE_C) begin
            state <= ST_DATA;
            hold_v <= 1'b0;
            len <= 16'd0;
            err <= 1'b0;
          end else state <= ST_DROP;
        ST_DATA: begin
          frm_valid <= hold_v;
          frm_data <= hold_d;
          frm_sof <= hold_v & hold_sof;
          if (gmii_rx_dv) begin
            hold_v <= 1'b1;
            hold_d <= gmii_rxd;
            hold_sof <= !hold_v;
            len <= len + {15'd0, len != 16'hFFFF};
            err <= err | gmii_rx_er;
          end else begin
            state <= ST_IDLE;
            hold_v <= 1'b0;
            frm_eof <= hold_v;
            frm_len <= len;
            frm_err <= hold_v & (err | (len > MAX_LEN) | (len == 16'd0));
          end
        end
        ST_DROP:
          if (!gmii_rx_dv && !boot) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  assign qual = !gmii_rx_dv && !gmii_rx_er && (gmii_rxd[7:4] == gmii_rxd[3:0]) && speed_ok(gmii_rxd[2:1]);
  always_comb st_next = (gmii_rxd[3:0] == st_last) ? st_cnt + {3'd0, st_cnt != 4'hF} : 4'd1;
  always_ff @(posedge rgmii_rxc or posedge rst)
    if (rst) begin
      st_last <= 4'd0;
      st_cnt <= 4'd0;
      link_up <= 1'b0;
      link_speed <= SPD_10;
      full_duplex <= 1'b0;
    end else if (!qual) st_cnt <= 4'd0;
    else begin
      st_cnt <= st_next;
      st_last <= gmii_rxd[3:0];
      if (st_next >= STABLE_C) {full_duplex, link_speed, link_up} <= gmii_rxd[3:0];
    end
endmodule

// File: tb/tb_rgmii_rx_frame.sv
// tb_rgmii_rx_frame: scoreboard bench for the RGMII receive framer
module tb_rgmii_rx_frame;
  import eth_rgmii_pkg::*;
  logic rgmii_rxc = 1'b0, rst = 1'b1, rgmii_rx_ctl = 1'b0;
  logic [3:0] rgmii_rxd = 4'd0;
  logic gmii_rx_clk, gmii_rx_dv, gmii_rx_er, frm_valid, frm_sof, frm_eof, frm_err;
  logic link_up, full_duplex;
  logic [1:0] link_speed;
  logic [7:0] gmii_rxd, frm_data;
  logic [15:0] frm_len;
  typedef struct packed {
    logic [7:0] d;
    logic sof;
    logic eof;
    logic err;
    logic [15:0] len;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int tests = 0, fails = 0, cyc = 0, sfd_cyc = -100;
  bit ignore = 1'b0;
  logic [3:0] idle_nib = 4'd0;

  rgmii_rx_frame dut (
    .rgmii_rxc(rgmii_rxc), .rst(rst), .rgmii_rx_ctl(rgmii_rx_ctl), .rgmii_rxd(rgmii_rxd),
    .gmii_rx_clk(gmii_rx_clk), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er), .gmii_rxd(gmii_rxd),
    .frm_valid(frm_valid), .frm_data(frm_data), .frm_sof(frm_sof), .frm_eof(frm_eof),
    .frm_err(frm_err), .frm_len(frm_len), .link_up(link_up), .link_speed(link_speed),
    .full_duplex(full_duplex)
  );

  always #4 rgmii_rxc = ~rgmii_rxc;
  always @(posedge rgmii_rxc) cyc <= cyc + 1;

  always @(negedge rgmii_rxc) begin
    if (gmii_rx_dv && gmii_rxd == ETH_SFD) sfd_cyc = cyc;
    if (frm_valid && !ignore) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_byte got data=%h sof=%b eof=%b, required no byte", frm_data, frm_sof, frm_eof);
      end else begin
        e = exp_q.pop_front();
        if (frm_data !== e.d || frm_sof !== e.sof || frm_eof !== e.eof ||
            (e.eof && (frm_err !== e.err || frm_len !== e.len))) begin
          fails++;
          $display("FAIL frame_byte got d=%h sof=%b eof=%b err=%b len=%0d, required d=%h sof=%b eof=%b err=%b len=%0d",
                   frm_data, frm_sof, frm_eof, frm_err, frm_len, e.d, e.sof, e.eof, e.err, e.len);
        end
      end
      if (frm_sof) begin
        tests++;
        if (cyc - sfd_cyc != 3) begin
          fails++;
          $display("FAIL sof_latency got %0d cycles after SFD, required 3", cyc - sfd_cyc);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic cr, input logic cf, input logic [7:0] b);
    @(negedge rgmii_rxc);
    #1;
    rgmii_rx_ctl = cr;
    rgmii_rxd = b[3:0];
    @(posedge rgmii_rxc);
    #1;
    rgmii_rx_ctl = cf;
    rgmii_rxd = b[7:4];
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, {idle_nib, idle_nib});
  endtask

  task automatic send_frame(input int npre, input int n, input int er_at, input bit push, input int ifg);
    repeat (npre) drive(1'b1, 1'b1, ETH_PREAMBLE);
    drive(1'b1, 1'b1, ETH_SFD);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = 8'(i) & 8'h3F;
      drive(1'b1, i != er_at, b);
      if (push) exp_q.push_back('{b, i == 0, i == n - 1, (er_at >= 0) || (n > 1522), 16'(n)});
    end
    idle(ifg);
  endtask

  task automatic drain(input string name);
    idle(8);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain got %0d bytes pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_status(input string name, input logic lu, input logic [1:0] sp, input logic fd);
    tests++;
    if ({link_up, link_speed, full_duplex} !== {lu, sp, fd}) begin
      fails++;
      $display("FAIL %s got link=%b speed=%b duplex=%b, required link=%b speed=%b duplex=%b",
               name, link_up, link_speed, full_duplex, lu, sp, fd);
    end
  endtask

  task automatic test_reset;
    idle(4);
    tests++;
    if ({gmii_rx_dv, gmii_rx_er, gmii_rxd, frm_valid, frm_data, frm_sof, frm_eof, frm_err, frm_len,
         link_up, link_speed, full_duplex} !== 40'd0) begin
      fails++;
      $display("FAIL reset_outputs got nonzero outputs, required all 0");
    end
    tests++;
    if (gmii_rx_clk !== rgmii_rxc) begin
      fails++;
      $display("FAIL rx_clk got %b, required %b", gmii_rx_clk, rgmii_rxc);
    end
    rst = 1'b0;
    idle(4);
    check_status("status_after_reset", 1'b0, SPD_10, 1'b0);
  endtask

  task automatic test_basic;
    send_frame(7, 64, -1, 1'b1, 4);
    drain("basic");
  endtask

  task automatic test_er;
    send_frame(7, 64, 10, 1'b1, 4);
    drain("er_pulse");
  endtask

  task automatic test_bad_preamble;
    drive(1'b1, 1'b1, 8'h55);
    drive(1'b1, 1'b1, 8'h55);
    drive(1'b1, 1'b1, 8'h5A);
    drive(1'b1, 1'b1, ETH_SFD);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 8'(i));
    idle(4);
    send_frame(7, 32, -1, 1'b1, 4);
    drain("bad_preamble");
  endtask

  task automatic test_status;
    idle_nib = 4'b1101;
    idle(5);
    check_status("status_1000_fd", 1'b1, SPD_1000, 1'b1);
    idle_nib = 4'b0000;
    idle(1);
    idle_nib = 4'b1101;
    idle(4);
    check_status("status_glitch", 1'b1, SPD_1000, 1'b1);
    idle_nib = 4'b0111;
    idle(5);
    check_status("status_speed11", 1'b1, SPD_1000, 1'b1);
    idle_nib = 4'b0011;
    idle(5);
    check_status("status_100_hd", 1'b1, SPD_100, 1'b0);
    idle_nib = 4'b1101;
    idle(5);
  endtask

  task automatic test_reset_mid;
    ignore = 1'b1;
    repeat (7) drive(1'b1, 1'b1, ETH_PREAMBLE);
    drive(1'b1, 1'b1, ETH_SFD);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 8'(i));
    rst = 1'b1;
    #1;
    tests++;
    if (frm_valid !== 1'b0 || frm_eof !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_stop got valid=%b eof=%b, required 0 0", frm_valid, frm_eof);
    end
    ignore = 1'b0;
    for (int i = 10; i < 13; i++) drive(1'b1, 1'b1, 8'(i));
    rst = 1'b0;
    for (int i = 13; i < 33; i++) drive(1'b1, 1'b1, 8'(i));
    idle(4);
    send_frame(7, 16, -1, 1'b1, 4);
    drain("reset_mid");
  endtask

  task automatic test_back_to_back;
    send_frame(7, 20, -1, 1'b1, 1);
    send_frame(1, 24, -1, 1'b1, 1);
    drain("back_to_back");
  endtask

  task automatic test_sizes;
    send_frame(7, 1530, -1, 1'b1, 4);
    drain("oversize");
    send_frame(7, 1, -1, 1'b1, 4);
    drain("single_byte");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_er;
    test_bad_preamble;
    test_status;
    test_reset_mid;
    test_back_to_back;
    test_sizes;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
